iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational shift/add/sub ALU.
- Operand width is generic. Operations are arithmetic right shift, logical right shift, subtract, add and logical left shift.
- Shifts run iteratively, one bit per cycle. Results come back through a valid/ready handshake, together with zero and signed-overflow flags.
- Sits between the operand-issue logic and the writeback stage of the team's MIPS datapath experiments.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- SHAMT_W, 3, shift-amount width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WIDTH  operand A (the value that is shifted).
- in_b  input  WIDTH  operand B.
- in_shamt  input  SHAMT_W  shift amount.
- op  input  3  operation select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_ans  output  WIDTH  result.
- out_zero  output  1  out_ans == 0.
- out_ovf  output  1  signed overflow (ADD/SUB only).
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_ans=0, out_zero=0, out_ovf=0, busy=0, internal counter=0.
- in_ready = (state==IDLE). It is combinational and 0 during reset.
- States:
  - IDLE. On accept (in_valid & in_ready at edge k), latch operands.
    - ADD, SUB, illegal op, or shift with shamt=0: go to DONE with the result registered at edge k.
    - Shift with shamt>0: go to SHIFT with cnt=eff_shamt.
  - SHIFT. Each cycle, shift the working register by one bit and decrement cnt. When cnt reaches 0 after the shift, go to DONE.
  - DONE. out_valid=1, and out_ans/flags are held stable. On out_ready=1, go to IDLE. The next request can be accepted on the following cycle at the earliest.
- Latency: out_valid is visible after edge k for single-cycle ops, and after edge k+eff_shamt for shifts.
- Op encoding:
  - 000: SRA. Fill with sign bit of in_a.
  - 001: SRL. Fill with 0.
  - 010: SUB, a-b.
  - 011: ADD, a+b.
  - 100: SLL. Fill with 0.
  - 101: MUL (optional feature).
  - 110, 111: illegal. out_ans=0, ovf=0, zero=1.
- Shift amount: eff_shamt = min(in_shamt, WIDTH). Once the shift saturates, SRL/SLL give 0 and SRA gives all sign bits.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - ovf for ADD = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
  - ovf for SUB = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - ovf=0 for shifts.
- Inputs are sampled only at accept. in_a, in_b, op and in_shamt may change freely afterwards.
- While busy, in_valid is ignored and no request is queued.
- out_ready while not in DONE has no effect.
- Reset asserted mid-SHIFT or mid-DONE returns to reset values immediately. The pending result is discarded.

Optional Feature:
- Macro: ITER_ALU_MUL_EN.
- Defined:
  - op 101 is an unsigned shift-add multiply over exactly WIDTH iterations. out_valid is visible after edge k+WIDTH.
  - out_ans is the low WIDTH bits of the product.
  - out_ovf=1 if any upper product bit is non-zero.
  - The FSM gains a MUL state (IDLE->MUL->DONE).
- Undefined: op 101 is treated as illegal (single-cycle, ans=0, zero=1, ovf=0). No MUL state or multiplier registers exist.

Test Plan (WIDTH=8, SHAMT_W=3):
- Reset and arithmetic:
  - Reset asserted -> all outputs 0, in_ready=0 while reset is high. After release, in_ready=1.
  - ADD 8'h7F+8'h01 -> out_ans=8'h80, ovf=1, zero=0, out_valid after 1 edge.
  - SUB 8'h05-8'h05 -> 8'h00, zero=1, ovf=0.
  - SUB 8'h80-8'h01 -> 8'h7F, ovf=1.
- Shifts on a=8'hB4, shamt=3:
  - SRA -> 8'hF6.
  - SRL -> 8'h16.
  - SLL -> 8'hA0.
  - Each has out_valid exactly 3 edges after accept, busy=1 throughout.
  - shamt=0 -> 8'hB4 after 1 edge.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> out_ans stable, in_ready=0, and no second result after out_ready=1 unless in_valid is re-asserted.
- Mid-operation reset: pulse reset asynchronously during SRA shamt=7 at cnt=4 -> outputs clear immediately without a clock edge. The next request (ADD 1+2) returns 8'h03 with no stale result.
- MUL with ITER_ALU_MUL_EN:
  - 8'h0F*8'h11 -> 8'hFF, ovf=0, valid after 8 edges.
  - 8'h10*8'h10 -> 8'h00, ovf=1, zero=1.
  - Without the macro, op 101 -> 8'h00, zero=1 after 1 edge.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative shift/add/sub ALU that shifts one bit per clock, with zero and signed-overflow flags.
// Latency: result visible after the accept edge for ADD/SUB/illegal/shamt=0, or eff_shamt edges later for shifts.
// Backpressure: the result is held in DONE until out_ready; in_ready is low whenever a request is in flight.
//
// Optional feature macro: ITER_ALU_MUL_EN. When defined, op 101 runs an unsigned shift-add multiply
// over WIDTH iterations. When undefined, op 101 is treated as an illegal op.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready       request handshake (in_ready = IDLE and not in reset)
//   in_a, in_b, in_shamt    operands and shift amount, sampled only at accept
//   op                      000 SRA, 001 SRL, 010 SUB, 011 ADD, 100 SLL, 101 MUL/illegal, 11x illegal
//   out_valid/out_ready     result handshake
//   out_ans, out_zero,      result, result==0, signed overflow (ADD/SUB; MUL upper-half non-zero)
//   out_ovf
//   busy                    state != IDLE
module iter_alu #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_ans,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               busy
);

  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  // Common width for comparing the shift amount against WIDTH without truncating either side.
  localparam int EXT_W = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
`ifdef ITER_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
`ifdef ITER_ALU_MUL_EN
    ,
    MUL
`endif
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] workReg;
  logic [2:0]       opReg;
  logic             outValid;
  logic [WIDTH-1:0] outAns;
  logic             outZero;
  logic             outOvf;

`ifdef ITER_ALU_MUL_EN
  logic [2*WIDTH-1:0] mulAcc;
  logic [2*WIDTH-1:0] mulCand;
  logic [WIDTH-1:0]   mulPlier;
  logic [2*WIDTH-1:0] mulAccNext;
`endif

  // Effective shift amount, saturated at WIDTH.
  logic [EXT_W-1:0] shamtExt;
  logic [CNT_W-1:0] effShamt;

  assign shamtExt = EXT_W'(in_shamt);
  assign effShamt = (shamtExt > EXT_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(shamtExt);

  // Single-cycle arithmetic on the live inputs; only consumed on the accept edge.
  logic [WIDTH-1:0] sumVal;
  logic [WIDTH-1:0] diffVal;
  logic             addOvf;
  logic             subOvf;
  logic             isShift;

  assign sumVal  = in_a + in_b;
  assign diffVal = in_a - in_b;
  assign addOvf  = (in_a[MSB] == in_b[MSB]) && (sumVal[MSB] != in_a[MSB]);
  assign subOvf  = (in_a[MSB] != in_b[MSB]) && (diffVal[MSB] != in_a[MSB]);
  assign isShift = (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);

  // Result for everything that completes on the accept edge. A shift only lands
  // here when its amount is zero, so it passes in_a through unchanged.
  logic [WIDTH-1:0] immAns;
  logic             immOvf;

  always_comb begin
    immAns = '0;
    immOvf = 1'b0;
    case (op)
      OP_SUB: begin
        immAns = diffVal;
        immOvf = subOvf;
      end
      OP_ADD: begin
        immAns = sumVal;
        immOvf = addOvf;
      end
      OP_SRA, OP_SRL, OP_SLL: immAns = in_a;
      default: immAns = '0;
    endcase
  end

  // One-bit step of the working register for the latched shift op.
  logic [WIDTH-1:0] shiftNext;

  always_comb begin
    shiftNext = '0;
    case (opReg)
      OP_SRA:  shiftNext = {workReg[MSB], workReg[MSB:1]};
      OP_SLL:  shiftNext = {workReg[MSB-1:0], 1'b0};
      default: shiftNext = {1'b0, workReg[MSB:1]};
    endcase
  end

`ifdef ITER_ALU_MUL_EN
  assign mulAccNext = mulAcc + (mulPlier[0] ? mulCand : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      workReg  <= '0;
      opReg    <= '0;
      outValid <= 1'b0;
      outAns   <= '0;
      outZero  <= 1'b0;
      outOvf   <= 1'b0;
`ifdef ITER_ALU_MUL_EN
      mulAcc   <= '0;
      mulCand  <= '0;
      mulPlier <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opReg   <= op;
            workReg <= in_a;
            if (isShift && (effShamt != '0)) begin
              state <= SHIFT;
              cnt   <= effShamt;
            end
`ifdef ITER_ALU_MUL_EN
            else if (op == OP_MUL) begin
              state    <= MUL;
              cnt      <= CNT_W'(WIDTH);
              mulAcc   <= '0;
              mulCand  <= {{WIDTH{1'b0}}, in_a};
              mulPlier <= in_b;
            end
`endif
            else begin
              state    <= DONE;
              outValid <= 1'b1;
              outAns   <= immAns;
              outZero  <= (immAns == '0);
              outOvf   <= immOvf;
            end
          end
        end

        SHIFT: begin
          workReg <= shiftNext;
          cnt     <= cnt - CNT_W'(1);
          // The last step's value goes straight to the output so DONE is reached on this edge.
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            outValid <= 1'b1;
            outAns   <= shiftNext;
            outZero  <= (shiftNext == '0);
            outOvf   <= 1'b0;
          end
        end

`ifdef ITER_ALU_MUL_EN
        MUL: begin
          mulAcc   <= mulAccNext;
          mulCand  <= mulCand << 1;
          mulPlier <= mulPlier >> 1;
          cnt      <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            outValid <= 1'b1;
            outAns   <= mulAccNext[WIDTH-1:0];
            outZero  <= (mulAccNext[WIDTH-1:0] == '0);
            outOvf   <= |mulAccNext[2*WIDTH-1:WIDTH];
          end
        end
`endif

        DONE: begin
          if (out_ready) begin
            state    <= IDLE;
            outValid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign out_valid = outValid;
  assign out_ans   = outAns;
  assign out_zero  = outZero;
  assign out_ovf   = outOvf;

endmodule

// File: tb/tb_iter_alu.sv
// Testbench for iter_alu: directed cases plus random requests against a behavioural model.
// Latency: not applicable.
// Backpressure: holds out_ready low for random stretches while presenting new requests.
module tb_iter_alu;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [SW-1:0] in_shamt;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_ans;
  logic          out_zero;
  logic          out_ovf;
  logic          busy;

  int nCompared   = 0;
  int nMismatched = 0;

  iter_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_shamt  (in_shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ans   (out_ans),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op: signed values,
  // true-range overflow, plain integer shifts and products.
  task automatic model(input logic [2:0] mop, input int a, input int b, input int sh,
                       output int ans, output int ovf, output int lat);
    int mask, half, n, sa, sb, s;
    longint p;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    n    = (sh > W) ? W : sh;
    sa   = (a >= half) ? a - (1 << W) : a;
    sb   = (b >= half) ? b - (1 << W) : b;
    ans  = 0;
    ovf  = 0;
    lat  = 0;
    case (mop)
      3'd0: begin ans = (sa >>> n) & mask; lat = n; end
      3'd1: begin ans = a >> n;            lat = n; end
      3'd2: begin s = sa - sb; ans = s & mask; ovf = (s >= half || s < -half) ? 1 : 0; end
      3'd3: begin s = sa + sb; ans = s & mask; ovf = (s >= half || s < -half) ? 1 : 0; end
      3'd4: begin ans = (a << n) & mask;   lat = n; end
`ifdef ITER_ALU_MUL_EN
      3'd5: begin
        p   = longint'(a) * longint'(b);
        ans = int'(p & longint'(mask));
        ovf = (p > longint'(mask)) ? 1 : 0;
        lat = W;
      end
`endif
      default: begin ans = 0; ovf = 0; lat = 0; end
    endcase
  endtask

  // Issues one request, measures edges from accept to out_valid, checks the
  // result, stalls the consumer for 'hold' cycles while offering new requests,
  // then completes the handshake and confirms nothing else comes out.
  task automatic runOp(input logic [2:0] o, input int a, input int b, input int sh,
                       input int expAns, input int expOvf, input int expLat,
                       input int hold, input string tag);
    int guard, edges, busyBad, stableBad, idleBad;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, ".rdy"}, in_ready, 1);
    in_valid = 1'b1;
    op       = o;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_shamt = sh[SW-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_shamt = SW'($urandom);
    edges   = 0;
    busyBad = 0;
    while (!out_valid && edges < 40) begin
      if (!busy || in_ready) busyBad++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".vld"}, out_valid, 1);
    check({tag, ".lat"}, edges, expLat);
    check({tag, ".busyRun"}, busyBad, 0);
    check({tag, ".ans"}, out_ans, expAns);
    check({tag, ".zero"}, out_zero, (expAns == 0) ? 1 : 0);
    check({tag, ".ovf"}, out_ovf, expOvf);
    check({tag, ".busyDone"}, busy, 1);
    held      = out_ans;
    stableBad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op       = 3'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_shamt = SW'($urandom);
      @(posedge clk); #1;
      if (out_ans !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stableBad++;
    end
    check({tag, ".hold"}, stableBad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".vldDrop"}, out_valid, 0);
    check({tag, ".idle"}, {busy, in_ready}, 2'b01);
    idleBad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) idleBad++;
    end
    check({tag, ".noExtra"}, idleBad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ea, eo, el, a, b, sh;
    logic [2:0] o;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_shamt  = '0;
    op        = '0;

    // Reset state, including in_ready held low for the whole reset pulse.
    #2 reset = 1'b1;
    #1;
    check("rst.outs", {out_valid, out_ans, out_zero, out_ovf, busy}, '0);
    check("rst.rdy", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    check("rst.rdyHeld", in_ready, 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("rst.rdyAfter", in_ready, 1);
    check("rst.outsAfter", {out_valid, out_ans, out_zero, out_ovf, busy}, '0);

    // Directed arithmetic and shift cases.
    runOp(3'b011, 'h7F, 'h01, 0, 'h80, 1, 0, 0, "add7f");
    runOp(3'b010, 'h05, 'h05, 0, 'h00, 0, 0, 1, "subEq");
    runOp(3'b010, 'h80, 'h01, 0, 'h7F, 1, 0, 0, "sub80");
    runOp(3'b000, 'hB4, 'h00, 3, 'hF6, 0, 3, 1, "sra3");
    runOp(3'b001, 'hB4, 'h00, 3, 'h16, 0, 3, 0, "srl3");
    runOp(3'b100, 'hB4, 'h00, 3, 'hA0, 0, 3, 2, "sll3");
    runOp(3'b000, 'hB4, 'h00, 0, 'hB4, 0, 0, 0, "sra0");
    runOp(3'b110, 'h12, 'h34, 5, 'h00, 0, 0, 0, "ill6");
    runOp(3'b111, 'hFF, 'hFF, 7, 'h00, 0, 0, 0, "ill7");

    // Consumer stalled for 3 cycles while new requests are offered.
    runOp(3'b011, 'h12, 'h34, 0, 'h46, 0, 0, 3, "bp");

    // Asynchronous reset in the middle of SRA shamt=7, at cnt=4.
    in_valid = 1'b1;
    op       = 3'b000;
    in_a     = 8'h80;
    in_b     = 8'h00;
    in_shamt = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("mr.busyPre", busy, 1);
    check("mr.ansPre", out_ans, 'h46);
    reset = 1'b1;
    #1;
    check("mr.outs", {out_valid, out_ans, out_zero, out_ovf, busy}, '0);
    check("mr.rdy", in_ready, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("mr.noStale", out_valid, 0);
    runOp(3'b011, 1, 2, 0, 'h03, 0, 0, 0, "mrAdd");

`ifdef ITER_ALU_MUL_EN
    runOp(3'b101, 'h0F, 'h11, 0, 'hFF, 0, W, 0, "mulFF");
    runOp(3'b101, 'h10, 'h10, 0, 'h00, 1, W, 1, "mulOvf");
`else
    runOp(3'b101, 'h0F, 'h11, 3, 'h00, 0, 0, 0, "op5ill");
`endif

    // Random requests checked against the model.
    for (int i = 0; i < 150; i++) begin
      o  = 3'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      sh = int'($urandom_range(0, 7));
      model(o, a, b, sh, ea, eo, el);
      runOp(o, a, b, sh, ea, eo, el, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
